// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and received-byte outputs of uart_rx
interface uart_rx_if;
  logic       rx;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output dout,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  dout,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, LSB first, mid-bit sampling with stop-bit check
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each mid-bit sample point.
module uart_rx #(
  parameter int CLOCK_FREQUENCY = 200000000,
  parameter int BAUD_RATE       = 9600
) (
  input  logic     clk,
  input  logic     resetn,
  uart_rx_if.master bus
);

  localparam logic [31:0] TIMER_MAX = 32'(CLOCK_FREQUENCY / BAUD_RATE - 1);
  localparam logic [31:0] HALF      = TIMER_MAX / 32'd2;
`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after HALF, so START runs one cycle longer.
  localparam logic [31:0] START_POINT = HALF + 32'd1;
`else
  localparam logic [31:0] START_POINT = HALF;
`endif

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        rx_meta;
  logic        rx_s;
  logic        rx_d;
  logic [31:0] count;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        decide;
  logic        sample;
  logic        fall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_dd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_dd <= 1'b1;
    end else begin
      rx_dd <= rx_d;
    end
  end

  // Because START ended one cycle late, a vote over counts TIMER_MAX-2..TIMER_MAX
  // in DATA/STOP covers the same line instants as the nominal mid-bit window.
  assign sample = (rx_dd & rx_d) | (rx_dd & rx_s) | (rx_d & rx_s);
`else
  assign sample = rx_s;
`endif

  assign fall     = rx_d & ~rx_s;
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    decide     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_next = START;
        end
      end
      START: begin
        if (count == START_POINT) begin
          decide     = 1'b1;
          state_next = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (count == TIMER_MAX) begin
          decide = 1'b1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        // Return to IDLE at the stop sample so a back-to-back start edge is seen.
        if (count == TIMER_MAX) begin
          decide     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count         <= 32'd0;
      bit_idx       <= 3'd0;
      shift         <= 8'h00;
      bus.dout      <= 8'h00;
      bus.valid     <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.valid     <= 1'b0;
      bus.frame_err <= 1'b0;
      // Every decision either changes state or starts the next data bit.
      if (state == IDLE || decide) begin
        count <= 32'd0;
      end else begin
        count <= count + 32'd1;
      end
      if (decide) begin
        case (state)
          START: begin
            bit_idx <= 3'd0;
          end
          DATA: begin
            shift[bit_idx] <= sample;
            bit_idx        <= bit_idx + 3'd1;
          end
          STOP: begin
            if (sample) begin
              bus.dout  <= shift;
              bus.valid <= 1'b1;
            end else begin
              bus.frame_err <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

  localparam int CLK_HZ    = 100;
  localparam int BAUD      = 10;
  localparam int TMAX      = CLK_HZ / BAUD - 1;
  localparam int HALF_BIT  = TMAX / 2;
  localparam int BIT_CYC   = TMAX + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT    = 2 + (HALF_BIT + 1) + 9 * BIT_CYC + 1 + 1;
  localparam bit GLITCH = 1'b1;
`else
  localparam int LAT    = 2 + (HALF_BIT + 1) + 9 * BIT_CYC + 1;
  localparam bit GLITCH = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] last_good = 8'h00;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  uart_rx_if bus();

  uart_rx #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (resetn && (bus.valid || bus.frame_err)) begin
      e.cyc  = cyc;
      e.kind = {bus.valid, bus.frame_err};
      e.data = bus.dout;
      obs_q.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) tick();
  endtask

  // Expected outcome comes from the frame rule: good stop bit -> valid with the byte,
  // bad stop bit -> frame_err with dout untouched, LAT cycles after the start edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit glitch);
    logic [9:0] bits;
    ev_t        e;
    bits   = {stop_ok, b, 1'b0};
    e.cyc  = cyc + LAT;
    e.kind = stop_ok ? 2'b10 : 2'b01;
    if (stop_ok) last_good = b;
    e.data = last_good;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < BIT_CYC; j++) begin
        bus.rx = bits[i] ^ (glitch && j == BIT_CYC / 2);
        tick();
      end
    end
  endtask

  task automatic flush(input string scen);
    int n;
    check({scen, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({scen, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      check({scen, "_kind"}, {30'd0, obs_q[i].kind}, {30'd0, exp_q[i].kind});
      check({scen, "_dout"}, {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic       act;
    logic [7:0] b;
    logic [9:0] bits;
    bit         ok;
    int         s;

    resetn = 1'b0;
    bus.rx = 1'b1;
    repeat (3) tick();
    check("rst_dout", bus.dout, 8'h00);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    resetn = 1'b1;
    tick();

    act = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      act = act | bus.busy | bus.valid | bus.frame_err;
    end
    check("idle_quiet", act, 1'b0);
    check("idle_dout", bus.dout, 8'h00);
    flush("idle");

    send_frame(8'hA5, 1'b1, GLITCH);
    idle(20);
    flush("a5");

    for (int k = 0; k < 8; k++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok, GLITCH);
      idle(ok ? $urandom_range(0, 12) : $urandom_range(1, 12));
    end
    idle(20);
    flush("rand");

    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(20);
    flush("b2b");

    send_frame(8'h55, 1'b0, 1'b0);
    idle(5);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    flush("ferr");

    s = cyc;
    bus.rx = 1'b0;
    repeat (3) tick();
    bus.rx = 1'b1;
    repeat (2) tick();
    check("glitch_busy_hi", {cyc == s + 5, bus.busy}, 2'b11);
    repeat (4) tick();
    check("glitch_busy_lo", {cyc == s + 9, bus.busy}, 2'b10);
    idle(20);
    flush("short");

    send_frame(8'h5A, 1'b0, 1'b0);
    bus.rx = 1'b0;
    repeat (300) tick();
    check("low_busy", bus.busy, 1'b0);
    idle(20);
    flush("held_low");

    bits = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < BIT_CYC; j++) begin
        bus.rx = bits[i];
        tick();
      end
    end
    bus.rx = bits[5];
    repeat (2) tick();
    check("abort_busy_pre", bus.busy, 1'b1);
    resetn = 1'b0;
    bus.rx = 1'b1;
    last_good = 8'h00;
    tick();
    resetn = 1'b1;
    tick();
    check("abort_busy", bus.busy, 1'b0);
    check("abort_dout", bus.dout, 8'h00);
    idle(150);
    flush("abort");
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(20);
    flush("resend");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
